mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of the single 256-bit
// cache-line port of the DDR3 memory device.
//   Master 0 is the CPU line-fill/write-back port.
//   Master 1 is the DMA/GPU line port.
// The winning request is registered toward the memory device. Read data and a
// one-cycle ack are returned to the granted master only.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN): a BUSY-state watchdog. After
// TIMEOUT_CYCLES cycles without s_ack_i it aborts the transaction, acks the
// master (read data forced to zero) and sets the sticky err_o. Without the
// macro, err_o is tied low and BUSY waits for s_ack_i indefinitely.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset (shared with the device)
//   mN_addr_i        master N line address (N = 0, 1)
//   mN_data_i        master N write line
//   mN_data_o        master N read line
//   mN_we_i/rd_i     master N write/read request, held until ack (we wins if both)
//   mN_ack_o         master N completion, 1-cycle pulse
//   s_addr_o/data_o  latched address / write line toward the memory device
//   s_data_i         read line from the memory device
//   s_we_o/s_rd_o    strobes to the device, held until s_ack_i
//   s_ack_i          device completion, 1-cycle pulse (ignored outside BUSY)
//   gnt_o            one-hot current grant, 00 when idle
//   err_o            sticky timeout flag
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  m0_addr_i,
  input  logic [255:0] m0_data_i,
  output logic [255:0] m0_data_o,
  input  logic         m0_we_i,
  input  logic         m0_rd_i,
  output logic         m0_ack_o,
  input  logic [31:0]  m1_addr_i,
  input  logic [255:0] m1_data_i,
  output logic [255:0] m1_data_o,
  input  logic         m1_we_i,
  input  logic         m1_rd_i,
  output logic         m1_ack_o,
  output logic [31:0]  s_addr_o,
  output logic [255:0] s_data_o,
  input  logic [255:0] s_data_i,
  output logic         s_we_o,
  output logic         s_rd_o,
  input  logic         s_ack_i,
  output logic [1:0]   gnt_o,
  output logic         err_o
);

  // The timeout counter must be able to represent TIMEOUT_CYCLES - 1.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_W)) begin : g_bad_timeout_cfg
    $error("mem_arbiter: TIMEOUT_CYCLES does not fit in TO_W bits");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t       state, state_next;
  logic         last_grant;   // index of the master granted most recently
  logic         cur;          // index of the master owning the current transaction
  logic         cur_write;    // current transaction is a write
  logic         req0, req1;
  logic         pick1;        // master 1 wins arbitration this cycle
  logic         sel_we;
  logic         start;        // grant edge
  logic         done;         // transaction completes (device ack or timeout)
  logic         timeout;
  logic [255:0] rd_line;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    req0       = m0_rd_i | m0_we_i;
    req1       = m1_rd_i | m1_we_i;
    // On a tie the master that did not win last time goes next.
    pick1      = req1 & (~req0 | ~last_grant);
    sel_we     = pick1 ? m1_we_i : m0_we_i;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i | timeout) begin
          done       = 1'b1;
          state_next = ACK;
        end
      end
      // Requests are not sampled here: the master just acked may still be
      // dropping its request.
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A completion without s_ack_i can only be a timeout, which returns zeros.
  // A coincident s_ack_i wins over the timeout.
  assign rd_line = s_ack_i ? s_data_i : '0;

  // NOTE: the datapath registers are reset along with the control state
  // because every output must read 0 from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      cur_write  <= 1'b0;
      s_addr_o   <= '0;
      s_data_o   <= '0;
      s_we_o     <= 1'b0;
      s_rd_o     <= 1'b0;
      gnt_o      <= 2'b00;
      m0_data_o  <= '0;
      m1_data_o  <= '0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      state <= state_next;
      if (start) begin
        s_addr_o   <= pick1 ? m1_addr_i : m0_addr_i;
        s_data_o   <= pick1 ? m1_data_i : m0_data_i;
        s_we_o     <= sel_we;
        s_rd_o     <= ~sel_we;
        gnt_o      <= pick1 ? 2'b10 : 2'b01;
        last_grant <= pick1;
        cur        <= pick1;
        cur_write  <= sel_we;
      end
      if (done) begin
        s_we_o <= 1'b0;
        s_rd_o <= 1'b0;
        if (cur) m1_ack_o <= 1'b1;
        else     m0_ack_o <= 1'b1;
        if (!cur_write) begin
          if (cur) m1_data_o <= rd_line;
          else     m0_data_o <= rd_line;
        end
      end
      if (state == ACK) begin
        m0_ack_o <= 1'b0;
        m1_ack_o <= 1'b0;
        gnt_o    <= 2'b00;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // to_cnt counts completed BUSY cycles. Matching TIMEOUT_CYCLES-1 marks the
  // last permitted BUSY cycle.
  assign timeout = (state == BUSY) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start)               to_cnt <= '0;
      else if (state == BUSY)  to_cnt <= to_cnt + 1'b1;
      if (timeout && !s_ack_i) err_q  <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule
